msk_frame_rx: RTL and testbench
===============================

MSK_FRAME_RX -- requirements
Module: msk_frame_rx

Interface
REQ-001 Parameter SPB, default 20: clocks per bit, in the range 4..255.
REQ-002 Parameter SYNC_WORD, default 16'hFF1A: frame sync pattern, matched MSB first.
REQ-003 Parameter MID_ADJ, default 0: signed offset added to the mid-bit sample phase, in the range -(SPB/2-1)..+(SPB/2-1).
REQ-004 Port clk, input, 1: single receive clock.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port data_in, input, 1: demodulated hard-decision bit stream, synchronous to clk, SPB clocks per bit.
REQ-007 Port byte_out, output, 8: received payload byte.
REQ-008 Port byte_valid, output, 1: one-cycle strobe qualifying byte_out.
REQ-009 Port sof, output, 1: high with byte_valid on the first payload byte.
REQ-010 Port eof, output, 1: high with byte_valid on the last payload byte.
REQ-011 Port sync_lock, output, 1: high from sync match until the frame ends or is aborted.

Function
REQ-012 Bit timing: the phase counter counts 0..SPB-1 and wraps.
- Forced to 0 on any cycle where data_in differs from its value registered on the previous cycle.
REQ-013 Sample strobe: data_in is sampled when phase == SPB/2+MID_ADJ.
- If an edge occurs on the sample cycle, the edge wins and no sample is taken that cycle.
REQ-014 Without edges, one sample is taken every SPB cycles; a long run of equal bits does not drift.
REQ-015 FSM states: HUNT, LEN, PAYLOAD.
REQ-016 HUNT: each sample shifts into a 16-bit register at the LSB.
- When register == SYNC_WORD: go to LEN, clear the bit counter, assert sync_lock on the next cycle.
REQ-017 LEN: collect 8 samples MSB first into the length register.
- Length 0: return to HUNT, clear sync_lock, no byte output.
- Otherwise: go to PAYLOAD.
REQ-018 PAYLOAD: every 8 samples assemble one byte MSB first.
- byte_out and byte_valid are driven on the clock after the 8th sample strobe.
- byte_valid is high for exactly one cycle.
REQ-019 sof is asserted on payload byte 1; eof is asserted on payload byte LEN; both are set together when LEN == 1.
REQ-020 After the eof byte: return to HUNT, clear the shift register to 0, clear sync_lock in the same cycle eof is asserted.
REQ-021 Sync is not re-searched during LEN or PAYLOAD.
REQ-022 byte_out holds its last value between strobes.
REQ-023 No backpressure: bytes are lost if the consumer is not ready.

Reset
REQ-024 On reset_n low, asynchronously:
- state = HUNT; phase, bit counter, shift register, length register = 0.
- byte_out = 0; byte_valid, sof, eof, sync_lock = 0.
REQ-025 Reset asserted mid-frame aborts the frame with no eof; reception resumes in HUNT after release.

Structure
REQ-026 Package msk_pkg holds:
- FSM state enum type.
- Default SYNC_WORD and SPB constants.
- Byte width constant.
REQ-027 Bit timing (REQ-012..014) is one sub-module, msk_bit_sync.
- Outputs: a sample strobe and the sampled bit.
REQ-028 Framing FSM and byte assembly live in msk_frame_rx.

Verification
REQ-029 Scenario 1: serial stream 10 10 00 00 00 33 00 00 00 FF FF FF FF 1A 01 00 (hex bytes, MSB first, 20 clk/bit) -> exactly one byte 8'h00 with sof=eof=1; sync_lock high from after 8'h1A until that strobe.
REQ-030 Scenario 2: FF 1A 03 A5 5A 3C -> bytes A5 (sof), 5A, 3C (eof).
- Each byte_valid is 160 clk apart.
- First byte_valid occurs 1 clk after the 8th payload sample.
REQ-031 Scenario 3: FF 1B 03 A5 5A 3C (one bit error) -> no byte_valid, sync_lock stays 0.
REQ-032 Scenario 4: Scenario 2 with each bit edge jittered by ±3 clk pseudo-randomly -> identical output bytes.
REQ-033 Scenario 5: reset_n pulsed low after the 2nd payload byte of Scenario 2, then Scenario 2 resent -> all outputs 0 during reset, no eof for the aborted frame, the full A5 5A 3C frame is received afterwards.
REQ-034 Scenario 6: FF 1A 00 followed by FF 1A 01 C3 -> nothing output for the first frame; a single byte C3 with sof=eof=1 for the second.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared types and defaults for the MSK frame receiver: FSM state encoding,
// default bit period / sync word, and payload byte width.
package msk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } msk_state_t;

  localparam int          MSK_SPB_DEF  = 20;
  localparam logic [15:0] MSK_SYNC_DEF = 16'hFF1A;
  localparam int          MSK_BYTE_W   = 8;

endpackage

// File: rtl/msk_bit_sync.sv
// Bit-timing recovery: free-running phase counter re-aligned on every data edge,
// strobing the live input once per bit at mid-bit; combinational strobe, no backpressure.
module msk_bit_sync #(
  parameter int SPB     = 20,
  parameter int MID_ADJ = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int                PH_W      = $clog2(SPB);
  localparam logic [PH_W-1:0]   SAMPLE_PH = PH_W'(SPB / 2 + MID_ADJ);
  localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(SPB - 1);

  logic            data_q;
  logic            data_edge;
  logic [PH_W-1:0] phase;

  assign data_edge = data_in ^ data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 1'b0;
      phase  <= '0;
    end else begin
      data_q <= data_in;
      if (data_edge || (phase == LAST_PH)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // A transition landing on the sample phase means the bit centre is unreliable; skip it.
  assign sample_stb = (phase == SAMPLE_PH) && !data_edge;
  assign sample_bit = data_in;

endmodule

// File: rtl/msk_frame_rx.sv
// Sync-word hunt, length capture and MSB-first byte assembly over a hard-decision bit stream;
// byte_valid one clk after the 8th bit strobe, no backpressure (bytes are dropped if unread).
module msk_frame_rx
  import msk_pkg::*;
#(
  parameter int          SPB       = MSK_SPB_DEF,
  parameter logic [15:0] SYNC_WORD = MSK_SYNC_DEF,
  parameter int          MID_ADJ   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_in,
  output logic [MSK_BYTE_W-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  sof,
  output logic                  eof,
  output logic                  sync_lock
);

  logic sample_stb;
  logic sample_bit;

  msk_bit_sync #(
    .SPB     (SPB),
    .MID_ADJ (MID_ADJ)
  ) u_bit_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .sample_stb (sample_stb),
    .sample_bit (sample_bit)
  );

  msk_state_t            state, state_nxt;
  logic [15:0]           shift_reg, shift_reg_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [MSK_BYTE_W-1:0] len_reg, len_reg_nxt;
  logic [MSK_BYTE_W-1:0] asm_reg, asm_reg_nxt;
  logic [MSK_BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [MSK_BYTE_W-1:0] byte_out_nxt;
  logic                  byte_valid_nxt, sof_nxt, eof_nxt, sync_lock_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HUNT;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      len_reg    <= '0;
      asm_reg    <= '0;
      byte_cnt   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      sync_lock  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_reg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      len_reg    <= len_reg_nxt;
      asm_reg    <= asm_reg_nxt;
      byte_cnt   <= byte_cnt_nxt;
      byte_out   <= byte_out_nxt;
      byte_valid <= byte_valid_nxt;
      sof        <= sof_nxt;
      eof        <= eof_nxt;
      sync_lock  <= sync_lock_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    shift_reg_nxt  = shift_reg;
    bit_cnt_nxt    = bit_cnt;
    len_reg_nxt    = len_reg;
    asm_reg_nxt    = asm_reg;
    byte_cnt_nxt   = byte_cnt;
    byte_out_nxt   = byte_out;
    byte_valid_nxt = 1'b0;
    sof_nxt        = 1'b0;
    eof_nxt        = 1'b0;
    sync_lock_nxt  = sync_lock;

    if (sample_stb) begin
      unique case (state)
        ST_HUNT: begin
          shift_reg_nxt = {shift_reg[14:0], sample_bit};
          if (shift_reg_nxt == SYNC_WORD) begin
            state_nxt     = ST_LEN;
            bit_cnt_nxt   = '0;
            sync_lock_nxt = 1'b1;
          end
        end
        ST_LEN: begin
          len_reg_nxt = {len_reg[MSK_BYTE_W-2:0], sample_bit};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt_nxt = '0;
            if (len_reg_nxt == '0) begin
              state_nxt     = ST_HUNT;
              sync_lock_nxt = 1'b0;
            end else begin
              state_nxt = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          asm_reg_nxt = {asm_reg[MSK_BYTE_W-2:0], sample_bit};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_out_nxt   = asm_reg_nxt;
            byte_valid_nxt = 1'b1;
            sof_nxt        = (byte_cnt == '0);
            byte_cnt_nxt   = byte_cnt + 1'b1;
            // Last byte: drop lock alongside eof and hunt from a clean shift register.
            if (byte_cnt_nxt == len_reg) begin
              eof_nxt       = 1'b1;
              state_nxt     = ST_HUNT;
              shift_reg_nxt = '0;
              sync_lock_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_msk_frame_rx.sv
// Directed bench for msk_frame_rx: serial frames driven bit by bit, received bytes,
// flags and strobe timing compared against hand-computed values.
module tb_msk_frame_rx;
  localparam int SPB = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data_in;
  logic [7:0] byte_out;
  logic       byte_valid, sof, eof, sync_lock;

  msk_frame_rx #(.SPB(SPB), .SYNC_WORD(16'hFF1A), .MID_ADJ(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .sof        (sof),
    .eof        (eof),
    .sync_lock  (sync_lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_byte[$];
  logic       rx_sof[$];
  logic       rx_eof[$];
  int         rx_cyc[$];
  int         sl_rise, sl_fall, sl_rises;
  logic       sl_prev = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin
      rx_byte.push_back(byte_out);
      rx_sof.push_back(sof);
      rx_eof.push_back(eof);
      rx_cyc.push_back(cyc);
    end
    if (sync_lock && !sl_prev) begin
      sl_rise  = cyc;
      sl_rises = sl_rises + 1;
    end
    if (!sync_lock && sl_prev) sl_fall = cyc;
    sl_prev = sync_lock;
  end

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         frame_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int nbits);
    data_in = 1'b0;
    tick(nbits * SPB);
  endtask

  // Sends tx_q MSB first; with jit set, each interior bit edge moves by -3..+3 clocks.
  task automatic send_frame(input bit jit);
    int jprev, jn, len, nb;
    jprev = 0;
    nb = 0;
    frame_start = cyc + 1;
    foreach (tx_q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        data_in = tx_q[i][b];
        len = SPB;
        nb++;
        if (jit) begin
          jn = (nb == tx_q.size() * 8) ? 0 : int'($urandom_range(6, 0)) - 3;
          len = SPB + jn - jprev;
          jprev = jn;
        end
        tick(len);
      end
    end
  endtask

  task automatic clear_rx();
    rx_byte.delete();
    rx_sof.delete();
    rx_eof.delete();
    rx_cyc.delete();
    sl_rises = 0;
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, rx_byte.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_byte.size(); i++) begin
      chk({tag, "_byte"}, rx_byte[i], exp_q[i]);
      chk({tag, "_sof"}, rx_sof[i], (i == 0));
      chk({tag, "_eof"}, rx_eof[i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_byte_out"}, byte_out, 8'h00);
    chk({tag, "_byte_valid"}, byte_valid, 1'b0);
    chk({tag, "_sof"}, sof, 1'b0);
    chk({tag, "_eof"}, eof, 1'b0);
    chk({tag, "_sync_lock"}, sync_lock, 1'b0);
  endtask

  initial begin
    sl_rises = 0;
    sl_rise  = 0;
    sl_fall  = 0;
    reset_n  = 1'b0;
    data_in  = 1'b0;
    tick(5);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(4);

    // Scenario 1: sync buried in noise, one zero byte.
    clear_rx();
    tx_q  = '{8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00,
              8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1A, 8'h01, 8'h00};
    exp_q = '{8'h00};
    send_frame(1'b0);
    idle(4);
    check_rx("s1");
    if (rx_cyc.size() > 0) chk("s1_valid_cyc", rx_cyc[0], frame_start + 127 * SPB + 11);
    chk("s1_lock_rises", sl_rises, 1);
    chk("s1_lock_rise_cyc", sl_rise, frame_start + 111 * SPB + 11);
    chk("s1_lock_fall_cyc", sl_fall, frame_start + 127 * SPB + 11);

    // Scenario 2: three-byte frame with strobe timing.
    clear_rx();
    tx_q  = '{8'hFF, 8'h1A, 8'h03, 8'hA5, 8'h5A, 8'h3C};
    exp_q = '{8'hA5, 8'h5A, 8'h3C};
    send_frame(1'b0);
    idle(4);
    check_rx("s2");
    if (rx_cyc.size() == 3) begin
      chk("s2_first_cyc", rx_cyc[0], frame_start + 31 * SPB + 11);
      chk("s2_gap1", rx_cyc[1] - rx_cyc[0], 160);
      chk("s2_gap2", rx_cyc[2] - rx_cyc[1], 160);
    end
    chk("s2_byte_hold", byte_out, 8'h3C);
    chk("s2_lock_after", sync_lock, 1'b0);

    // Scenario 3: corrupted sync word.
    clear_rx();
    tx_q  = '{8'hFF, 8'h1B, 8'h03, 8'hA5, 8'h5A, 8'h3C};
    exp_q.delete();
    send_frame(1'b0);
    idle(4);
    check_rx("s3");
    chk("s3_lock_rises", sl_rises, 0);

    // Scenario 4: scenario 2 with jittered edges.
    clear_rx();
    tx_q  = '{8'hFF, 8'h1A, 8'h03, 8'hA5, 8'h5A, 8'h3C};
    exp_q = '{8'hA5, 8'h5A, 8'h3C};
    send_frame(1'b1);
    idle(4);
    check_rx("s4");

    // Scenario 5: reset after the second payload byte, then full resend.
    clear_rx();
    tx_q = '{8'hFF, 8'h1A, 8'h03, 8'hA5, 8'h5A};
    send_frame(1'b0);
    chk("s5_pre_count", rx_byte.size(), 2);
    chk("s5_pre_lock", sync_lock, 1'b1);
    reset_n = 1'b0;
    data_in = 1'b0;
    #1;
    check_outputs_zero("s5_async");
    tick(3 * SPB);
    check_outputs_zero("s5_held");
    chk("s5_abort_count", rx_byte.size(), 2);
    chk("s5_abort_no_eof", (rx_eof.size() == 2) ? (rx_eof[0] | rx_eof[1]) : 1'b1, 1'b0);
    reset_n = 1'b1;
    idle(4);
    clear_rx();
    tx_q  = '{8'hFF, 8'h1A, 8'h03, 8'hA5, 8'h5A, 8'h3C};
    exp_q = '{8'hA5, 8'h5A, 8'h3C};
    send_frame(1'b0);
    idle(4);
    check_rx("s5");

    // Scenario 6: zero-length frame followed by a one-byte frame.
    clear_rx();
    tx_q = '{8'hFF, 8'h1A, 8'h00};
    send_frame(1'b0);
    idle(2);
    chk("s6_empty_count", rx_byte.size(), 0);
    chk("s6_empty_lock", sync_lock, 1'b0);
    tx_q  = '{8'hFF, 8'h1A, 8'h01, 8'hC3};
    exp_q = '{8'hC3};
    send_frame(1'b0);
    idle(4);
    check_rx("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
